// File: rtl/mdu_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package mdu_pkg;

    // Widest result the sign-fix helper handles; WIDTH must not exceed MaxBits/2.
    localparam int unsigned MaxBits = 128;

    typedef enum logic [1:0] {
        OpMult  = 2'b00,
        OpMultu = 2'b01,
        OpDiv   = 2'b10,
        OpDivu  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } state_e;

    function automatic logic [MaxBits-1:0] neg_if(input logic [MaxBits-1:0] value,
                                                  input logic               flag);
        return flag ? (~value + 1'b1) : value;
    endfunction

    function automatic logic [MaxBits-1:0] dbz_quot();
        return '1;
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Start/ready handshake and result bus between the execute stage and mdu_iter.
interface mdu_iter_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 dbz_o;

    modport master (
        output start_i, annul_i, op_i, a_i, b_i,
        input  result_o, ready_o, busy_o, dbz_o
    );

    modport slave (
        input  start_i, annul_i, op_i, a_i, b_i,
        output result_o, ready_o, busy_o, dbz_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle,
// sharing one 2*WIDTH accumulator. Operands are magnitudes; signs are fixed up in FIX.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic        clk,
    input logic        rst,
    mdu_iter_if.slave  bus_io
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   opb_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               neg_lo_q;
    logic               neg_hi_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     hi_sum;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] fix_result;
    logic [2*WIDTH-1:0] dbz_result;

    always_comb begin
        // op_i[0] clear selects the signed variants.
        a_neg    = ~bus_io.op_i[0] & bus_io.a_i[WIDTH-1];
        b_neg    = ~bus_io.op_i[0] & bus_io.b_i[WIDTH-1];
        a_abs    = a_neg ? (~bus_io.a_i + 1'b1) : bus_io.a_i;
        b_abs    = b_neg ? (~bus_io.b_i + 1'b1) : bus_io.b_i;

        // Multiply: acc = {hi, multiplier}; add multiplicand to hi on LSB, shift right.
        hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
        mul_next = {hi_sum, acc_q[WIDTH-1:1]};

        // Divide: acc = {remainder, quotient}; the shifted remainder needs WIDTH+1 bits.
        shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        ge       = shifted >= {1'b0, opb_q};
        rem_next = ge ? WIDTH'(shifted - {1'b0, opb_q}) : shifted[WIDTH-1:0];
        div_next = {rem_next, acc_q[WIDTH-2:0], ge};

        if (is_div_q) begin
            fix_result = {WIDTH'(neg_if(MaxBits'(acc_q[2*WIDTH-1:WIDTH]), neg_hi_q)),
                          WIDTH'(neg_if(MaxBits'(acc_q[WIDTH-1:0]), neg_lo_q))};
        end else begin
            fix_result = (2*WIDTH)'(neg_if(MaxBits'(acc_q), neg_lo_q));
        end

        dbz_result = {bus_io.a_i, WIDTH'(dbz_quot())};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else if (bus_io.annul_i) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start_i) begin
                        is_div_q <= bus_io.op_i[1];
                        if (bus_io.op_i[1] && (bus_io.b_i == '0)) begin
                            result_q <= dbz_result;
                            dbz_q    <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            opb_q    <= b_abs;
                            acc_q    <= {{WIDTH{1'b0}}, a_abs};
                            neg_lo_q <= a_neg ^ b_neg;
                            neg_hi_q <= a_neg;
                            cnt_q    <= '0;
                            state_q  <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    result_q <= fix_result;
                    dbz_q    <= 1'b0;
                    state_q  <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.result_o = result_q;
    assign bus_io.dbz_o    = dbz_q;
    assign bus_io.busy_o   = (state_q != StIdle);
    assign bus_io.ready_o  = (state_q == StDone);

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter at WIDTH=32: directed vectors, annul, reset, busy-start, random.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [63:0] res;
        logic        dbz;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] last_res = '0;
    exp_t sb_q[$];

    mdu_iter_if #(.WIDTH(W)) bus ();

    mdu_iter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        e.dbz = 1'b0;
        e.lat = W + 2;
        e.res = '0;
        case (op)
            OpMult:  e.res = sa * sb;
            OpMultu: e.res = 64'(a) * 64'(b);
            default: begin
                if (b == 32'd0) begin
                    e.res = {a, 32'hFFFF_FFFF};
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else if (op == OpDiv) begin
                    e.res[31:0]  = 32'(sa / sb);
                    e.res[63:32] = 32'(sa % sb);
                end else begin
                    e.res = {a % b, a / b};
                end
            end
        endcase
        return e;
    endfunction

    // Drives one start pulse; returns at the negedge of cycle 1.
    task automatic drive_start(input op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        tests++;
        if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_before_start: ready=%b busy=%b, want 0 0",
                     bus.ready_o, bus.busy_o);
        end
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.a_i     = a;
        bus.b_i     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    // Waits for ready from cycle 1 and compares against the scoreboard head.
    task automatic collect(input string name);
        int   n = 1;
        bit   got = 0;
        exp_t e;
        tests++;
        if (bus.busy_o !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_cycle1: busy=%b, want 1", name, bus.busy_o);
        end
        while (!got && n <= 200) begin
            if (bus.ready_o === 1'b1) got = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        e = sb_q.pop_front();
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s timeout: no ready within 200 cycles", name);
        end else begin
            if (bus.result_o !== e.res) begin
                fails++;
                $display("FAIL %s result: got %h, want %h", name, bus.result_o, e.res);
            end
            tests++;
            if (bus.dbz_o !== e.dbz) begin
                fails++;
                $display("FAIL %s dbz: got %b, want %b", name, bus.dbz_o, e.dbz);
            end
            tests++;
            if (n != e.lat) begin
                fails++;
                $display("FAIL %s latency: ready in cycle %0d, want %0d", name, n, e.lat);
            end
        end
        last_res = e.res;
    endtask

    task automatic run_op(input string name, input op_e op, input logic [31:0] a,
                          input logic [31:0] b);
        sb_q.push_back(model(op, a, b));
        drive_start(op, a, b);
        collect(name);
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.a_i     = '0;
        bus.b_i     = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.result_o !== 64'd0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.dbz_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: result=%h ready=%b busy=%b dbz=%b, want all 0",
                     bus.result_o, bus.ready_o, bus.busy_o, bus.dbz_o);
        end
    endtask

    task automatic test_directed();
        run_op("mult_neg3x5", OpMult, 32'hFFFF_FFFD, 32'd5);
        run_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("divu_by_zero", OpDivu, 32'h0000_1234, 32'd0);
        run_op("div_neg7by2", OpDiv, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_7by2", OpDivu, 32'd7, 32'd2);
        run_op("div_minneg_by_m1", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("mult_minneg", OpMult, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_annul();
        drive_start(OpDiv, 32'd100, 32'd7);
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            tests++;
            if (bus.ready_o !== 1'b0) begin
                fails++;
                $display("FAIL annul_no_ready: ready=1 in cycle %0d, want 0", c);
            end
        end
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        tests++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL annul_idle: busy=%b ready=%b in cycle 11, want 0 0",
                     bus.busy_o, bus.ready_o);
        end
        tests++;
        if (bus.result_o !== last_res) begin
            fails++;
            $display("FAIL annul_result_kept: got %h, want %h", bus.result_o, last_res);
        end
        sb_q.push_back(model(OpMultu, 32'd6, 32'd7));
        bus.start_i = 1'b1;
        bus.op_i    = OpMultu;
        bus.a_i     = 32'd6;
        bus.b_i     = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start_i = 1'b0;
        collect("multu_after_annul");
    endtask

    task automatic test_reset_mid();
        run_op("divu_zero_pre_reset", OpDivu, 32'h0000_5678, 32'd0);
        drive_start(OpMult, 32'd3, 32'd4);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if (bus.result_o !== 64'd0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0 ||
            bus.dbz_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: result=%h ready=%b busy=%b dbz=%b, want all 0",
                     bus.result_o, bus.ready_o, bus.busy_o, bus.dbz_o);
        end
        @(negedge clk);
        rst = 1'b0;
        last_res = '0;
    endtask

    task automatic test_start_while_busy();
        int   rdy = 0;
        exp_t e;
        e = model(OpMultu, 32'd3, 32'd4);
        drive_start(OpMultu, 32'd3, 32'd4);
        bus.start_i = 1'b1;
        bus.op_i    = OpMult;
        bus.a_i     = 32'd9;
        bus.b_i     = 32'd9;
        for (int n = 1; n <= W + 6; n++) begin
            if (n == W + 1) bus.start_i = 1'b0;
            if (bus.ready_o === 1'b1) begin
                rdy++;
                tests++;
                if (bus.result_o !== e.res || n != W + 2) begin
                    fails++;
                    $display("FAIL busy_start_result: got %h in cycle %0d, want %h in cycle %0d",
                             bus.result_o, n, e.res, W + 2);
                end
            end
            @(negedge clk);
        end
        tests++;
        if (rdy != 1) begin
            fails++;
            $display("FAIL busy_start_pulses: %0d ready pulses, want 1", rdy);
        end
        last_res = e.res;
    endtask

    task automatic test_back_to_back();
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 8; i++) begin
            op = op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if (i == 1) b = 32'd1;
            run_op("random", op, a, b);
        end
        @(negedge clk);
        tests++;
        if (bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            fails++;
            $display("FAIL final_idle: ready=%b busy=%b, want 0 0", bus.ready_o, bus.busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
